// File: rtl/byte_mem_sequencer.sv
// MEM-stage load/store sequencer: splits one RV32I load/store into 1, 2 or 4
// little-endian byte accesses on a byte-wide memory port and extends load data.
module byte_mem_sequencer #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        func3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic              resp_fault,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [32:0] LAST_ADDR = 33'(DEPTH - 1);

  state_t             state_r;
  state_t             state_s;
  logic               read_r;
  logic               fault_r;
  logic [2:0]         func3_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [31:0]        wdata_r;
  logic [31:0]        buf_r;
  logic [2:0]         n_r;
  logic [1:0]         k_r;

  logic               accept_s;
  logic [2:0]         n_req_s;
  logic               func3_ok_s;
  logic [32:0]        end_addr_s;
  logic               fault_s;
  logic               last_byte_s;

  // Sign- or zero-extend the assembled load buffer according to funct3.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] b);
    logic [31:0] res;
    case (f3)
      3'b000:  res = {{24{b[7]}}, b[7:0]};
      3'b001:  res = {{16{b[15]}}, b[15:0]};
      3'b010:  res = b;
      3'b100:  res = {24'd0, b[7:0]};
      3'b101:  res = {16'd0, b[15:0]};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Accept decode, access size and fault classification of the incoming request.
  always_comb begin
    accept_s   = (state_r == ST_IDLE) & req_valid & (req_read | req_write);
    n_req_s    = 3'd4;
    func3_ok_s = 1'b0;
    case (func3[1:0])
      2'b00:   n_req_s = 3'd1;
      2'b01:   n_req_s = 3'd2;
      default: n_req_s = 3'd4;
    endcase
    if (req_read & !req_write) begin
      case (func3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: func3_ok_s = 1'b1;
        default:                                 func3_ok_s = 1'b0;
      endcase
    end else if (req_write & !req_read) begin
      case (func3)
        3'b000, 3'b001, 3'b010: func3_ok_s = 1'b1;
        default:                func3_ok_s = 1'b0;
      endcase
    end else begin
      func3_ok_s = 1'b0;
    end
    // 33-bit sum so an access running past the top never wraps to address 0
    end_addr_s = {1'b0, addr} + {30'd0, n_req_s} - 33'd1;
    fault_s    = (req_read & req_write) | !func3_ok_s | (end_addr_s > LAST_ADDR);
  end

  assign last_byte_s = ({1'b0, k_r} == (n_r - 3'd1));

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = fault_s ? ST_DONE : ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (last_byte_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, request latch, byte counter and load buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      read_r  <= 1'b0;
      fault_r <= 1'b0;
      func3_r <= 3'd0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      buf_r   <= 32'd0;
      n_r     <= 3'd1;
      k_r     <= 2'd0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            read_r  <= req_read;
            fault_r <= fault_s;
            func3_r <= func3;
            addr_r  <= addr[ADDR_W-1:0];
            wdata_r <= wdata;
            buf_r   <= 32'd0;
            n_r     <= n_req_s;
            k_r     <= 2'd0;
          end
        end
        ST_ACCESS: begin
          k_r <= last_byte_s ? 2'd0 : k_r + 2'd1;
          if (read_r) begin
            case (k_r)
              2'd0:    buf_r[7:0]   <= mem_rdata;
              2'd1:    buf_r[15:8]  <= mem_rdata;
              2'd2:    buf_r[23:16] <= mem_rdata;
              default: buf_r[31:24] <= mem_rdata;
            endcase
          end
        end
        default: k_r <= 2'd0;
      endcase
    end
  end

  // Output decode purely from registered state; only stall sees the live request.
  always_comb begin
    req_ready  = 1'b0;
    stall      = 1'b0;
    resp_valid = 1'b0;
    resp_fault = 1'b0;
    rdata      = 32'd0;
    mem_addr   = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 8'd0;
    case (state_r)
      ST_IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid & (req_read | req_write);
      end
      ST_ACCESS: begin
        stall    = 1'b1;
        mem_addr = addr_r + {{(ADDR_W-2){1'b0}}, k_r};
        mem_re   = read_r;
        mem_we   = !read_r;
        if (!read_r) begin
          case (k_r)
            2'd0:    mem_wdata = wdata_r[7:0];
            2'd1:    mem_wdata = wdata_r[15:8];
            2'd2:    mem_wdata = wdata_r[23:16];
            default: mem_wdata = wdata_r[31:24];
          endcase
        end else begin
          mem_wdata = 8'd0;
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_fault = fault_r;
        if (read_r & !fault_r) begin
          rdata = extend_load(func3_r, buf_r);
        end else begin
          rdata = 32'd0;
        end
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule
